// File: rtl/dffq_delay_line.sv
// rtl/dffq_delay_line.sv - scannable WIDTH x DEPTH pipeline register with valid tracking
//
// Purpose:
//   A WIDTH-bit by DEPTH-stage chain of rising-edge flip-flops for bus retiming
//   and fixed-latency delay matching. Each stage carries a valid bit. All data
//   bits also form one serial scan chain.
//
// Ports:
//   CLK  in   1                 clock, all state updates on the rising edge
//   RST  in   1                 synchronous active-high reset
//   EN   in   1                 advance the pipeline by one stage
//   D    in   WIDTH             data into stage 0
//   DV   in   1                 valid flag accompanying D
//   SE   in   1                 scan enable (takes priority over EN)
//   SI   in   1                 scan serial input
//   Q    out  WIDTH             data of the last stage
//   QV   out  1                 valid of the last stage
//   SO   out  1                 scan serial output (MSB of the last stage)
//   OCC  out  clog2(DEPTH+1)    number of stages holding a valid word
module dffq_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             EN,
  input  logic [WIDTH-1:0]                 D,
  input  logic                             DV,
  input  logic                             SE,
  input  logic                             SI,
  output logic [WIDTH-1:0]                 Q,
  output logic                             QV,
  output logic                             SO,
  output logic [$clog2(DEPTH+1)-1:0]       OCC
);

  localparam int CHAIN_W = WIDTH * DEPTH;
  localparam int OCC_W   = $clog2(DEPTH + 1);

  // Stage k occupies chain bits [k*WIDTH +: WIDTH], so the packed vector is
  // directly the scan chain with index j = k*WIDTH + b.
  logic [CHAIN_W-1:0] chain_q, chain_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [OCC_W-1:0]   occ_c;

  always_comb begin
    chain_d = chain_q;
    valid_d = valid_q;
    if (SE) begin
      // Scan shift moves every data bit one place up the chain; valid bits
      // are not part of the chain and hold.
      chain_d[0] = SI;
      for (int j = 1; j < CHAIN_W; j++) begin
        chain_d[j] = chain_q[j-1];
      end
    end else if (EN) begin
      chain_d[WIDTH-1:0] = D;
      valid_d[0]         = DV;
      for (int k = 1; k < DEPTH; k++) begin
        chain_d[k*WIDTH +: WIDTH] = chain_q[(k-1)*WIDTH +: WIDTH];
        valid_d[k]                = valid_q[k-1];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      chain_q <= {DEPTH{RESET_VAL}};
      valid_q <= '0;
    end else begin
      chain_q <= chain_d;
      valid_q <= valid_d;
    end
  end

  // Occupancy depends only on the valid registers, never on inputs.
  always_comb begin
    occ_c = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_c = occ_c + OCC_W'(valid_q[k]);
    end
  end

  assign Q   = chain_q[CHAIN_W-1 -: WIDTH];
  assign QV  = valid_q[DEPTH-1];
  assign SO  = chain_q[CHAIN_W-1];
  assign OCC = occ_c;

endmodule

// File: tb/tb_dffq_delay_line.sv
// tb/tb_dffq_delay_line.sv - self-checking bench for dffq_delay_line
module tb_dffq_delay_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, DEPTH=4, RESET_VAL=8'hA5
  logic       rst_a = 1'b0, en_a = 1'b0, dv_a = 1'b0, se_a = 1'b0, si_a = 1'b0;
  logic [7:0] d_a = 8'h00;
  logic [7:0] q_a;
  logic       qv_a, so_a;
  logic [2:0] occ_a;

  // Instance B: WIDTH=1, DEPTH=1
  logic       rst_b = 1'b0, en_b = 1'b0, dv_b = 1'b0, se_b = 1'b0, si_b = 1'b0;
  logic [0:0] d_b = 1'b0;
  logic [0:0] q_b;
  logic       qv_b, so_b;
  logic [0:0] occ_b;

  dffq_delay_line #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'hA5)) u_dut_a (
    .CLK(clk), .RST(rst_a), .EN(en_a), .D(d_a), .DV(dv_a), .SE(se_a), .SI(si_a),
    .Q(q_a), .QV(qv_a), .SO(so_a), .OCC(occ_a)
  );

  dffq_delay_line #(.WIDTH(1), .DEPTH(1), .RESET_VAL(1'b0)) u_dut_b (
    .CLK(clk), .RST(rst_b), .EN(en_b), .D(d_b), .DV(dv_b), .SE(se_b), .SI(si_b),
    .Q(q_b), .QV(qv_b), .SO(so_b), .OCC(occ_b)
  );

  int n_vec = 0;
  int n_err = 0;
  logic chk = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: stage words and valid flags as plain arrays.
  logic [7:0] ms_a [4];
  logic       mv_a [4];
  logic       md_b, mv_b;

  always @(posedge clk) begin
    if (rst_a) begin
      for (int k = 0; k < 4; k++) begin
        ms_a[k] <= 8'hA5;
        mv_a[k] <= 1'b0;
      end
    end else if (se_a) begin
      for (int k = 0; k < 4; k++)
        ms_a[k] <= {ms_a[k][6:0], (k == 0) ? si_a : ms_a[k-1][7]};
    end else if (en_a) begin
      ms_a[0] <= d_a;
      mv_a[0] <= dv_a;
      for (int k = 1; k < 4; k++) begin
        ms_a[k] <= ms_a[k-1];
        mv_a[k] <= mv_a[k-1];
      end
    end
    if (rst_b) begin
      md_b <= 1'b0;
      mv_b <= 1'b0;
    end else if (se_b) begin
      md_b <= si_b;
    end else if (en_b) begin
      md_b <= d_b[0];
      mv_b <= dv_b;
    end
  end

  function automatic int occ_model();
    int c = 0;
    for (int k = 0; k < 4; k++) c += int'(mv_a[k]);
    return c;
  endfunction

  // Compare process: every cycle once both instances have been reset.
  always @(negedge clk) begin
    if (chk) begin
      check("A_Q",   32'(q_a),   32'(ms_a[3]));
      check("A_QV",  32'(qv_a),  32'(mv_a[3]));
      check("A_SO",  32'(so_a),  32'(ms_a[3][7]));
      check("A_OCC", 32'(occ_a), 32'(occ_model()));
      check("B_Q",   32'(q_b),   32'(md_b));
      check("B_QV",  32'(qv_b),  32'(mv_b));
      check("B_SO",  32'(so_b),  32'(md_b));
      check("B_OCC", 32'(occ_b), 32'(mv_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_a(input logic r, input logic se, input logic en,
                        input logic [7:0] d, input logic dv, input logic si);
    rst_a = r; se_a = se; en_a = en; d_a = d; dv_a = dv; si_a = si;
    tick();
  endtask

  task automatic step_b(input logic r, input logic se, input logic en,
                        input logic d, input logic dv, input logic si);
    rst_b = r; se_b = se; en_b = en; d_b = d; dv_b = dv; si_b = si;
    tick();
  endtask

  logic [31:0] prior;
  logic [31:0] pat;
  logic [1:0]  bvec [5];

  initial begin
    // Reset both instances; A sees EN=1 and D=FF which must be ignored.
    rst_b = 1'b1;
    step_a(1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0);
    rst_b = 1'b0;
    chk = 1'b1;
    check("rst_Q",   32'(q_a),   32'hA5);
    check("rst_QV",  32'(qv_a),  32'h0);
    check("rst_OCC", 32'(occ_a), 32'h0);
    check("rst_SO",  32'(so_a),  32'h1);
    check("rstB_Q",  32'(q_b),   32'h0);

    // Streaming 1..5 with EN and DV held high.
    for (int i = 1; i <= 5; i++) begin
      step_a(1'b0, 1'b0, 1'b1, 8'(i), 1'b1, 1'b0);
      check("str_OCC", 32'(occ_a), (i < 4) ? i : 4);
      check("str_Q",   32'(q_a),   (i >= 4) ? i - 3 : 32'hA5);
      check("str_QV",  32'(qv_a),  (i >= 4) ? 1 : 0);
    end

    // Scan in DEADBEEF so the chain ends equal to it; SO shows prior contents.
    prior = 32'h02030405;
    pat   = 32'hDEADBEEF;
    for (int i = 0; i < 32; i++) begin
      check("scan_SO", 32'(so_a), 32'(prior[31-i]));
      step_a(1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, pat[31-i]);
      check("scan_OCC", 32'(occ_a), 32'd4);
    end
    check("scan_Q",  32'(q_a),  32'hDE);
    check("scan_QV", 32'(qv_a), 32'h1);
    step_a(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    check("unscan_Q1", 32'(q_a), 32'hAD);
    step_a(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    check("unscan_Q2", 32'(q_a), 32'hBE);
    step_a(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    check("unscan_Q3", 32'(q_a), 32'hEF);

    // Stall and bubbles from an empty pipeline.
    step_a(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step_a(1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0);
    step_a(1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, 1'b0, 1'b0, 8'h99, 1'b1, 1'b0);
      check("stall_Q",   32'(q_a),   32'hA5);
      check("stall_OCC", 32'(occ_a), 32'd1);
    end
    step_a(1'b0, 1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
    check("bub_OCC", 32'(occ_a), 32'd2);
    step_a(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check("bub_Q1",  32'(q_a),  32'h11);
    check("bub_QV1", 32'(qv_a), 32'h1);
    check("bub_OCC1", 32'(occ_a), 32'd2);
    step_a(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check("bub_Q2",  32'(q_a),  32'h22);
    check("bub_QV2", 32'(qv_a), 32'h0);
    step_a(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    check("bub_Q3",  32'(q_a),  32'h33);
    check("bub_QV3", 32'(qv_a), 32'h1);

    // Reset mid-stream with SE and EN also high.
    step_a(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step_a(1'b0, 1'b0, 1'b1, 8'h10, 1'b1, 1'b0);
    step_a(1'b0, 1'b0, 1'b1, 8'h20, 1'b1, 1'b0);
    step_a(1'b0, 1'b0, 1'b1, 8'h30, 1'b1, 1'b0);
    check("mid_OCC3", 32'(occ_a), 32'd3);
    step_a(1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
    check("mid_Q",   32'(q_a),   32'hA5);
    check("mid_OCC", 32'(occ_a), 32'd0);
    check("mid_QV",  32'(qv_a),  32'h0);
    for (int i = 1; i <= 4; i++) begin
      step_a(1'b0, 1'b0, 1'b1, (i == 1) ? 8'h77 : 8'h00, (i == 1), 1'b0);
      check("lat_Q",  32'(q_a),  (i == 4) ? 32'h77 : 32'hA5);
      check("lat_QV", 32'(qv_a), (i == 4) ? 1 : 0);
    end
    step_a(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // DEPTH=1, WIDTH=1 instance: {d, dv} pairs.
    bvec[0] = 2'b11; bvec[1] = 2'b01; bvec[2] = 2'b10; bvec[3] = 2'b11; bvec[4] = 2'b00;
    for (int i = 0; i < 5; i++) begin
      step_b(1'b0, 1'b0, 1'b1, bvec[i][1], bvec[i][0], 1'b0);
      check("b_Q",   32'(q_b),   32'(bvec[i][1]));
      check("b_SO",  32'(so_b),  32'(bvec[i][1]));
      check("b_OCC", 32'(occ_b), 32'(bvec[i][0]));
    end
    step_b(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("b_stall_Q", 32'(q_b), 32'h0);
    step_b(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("b_scan_Q",   32'(q_b),   32'h1);
    check("b_scan_OCC", 32'(occ_b), 32'h0);
    step_b(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("b_rst_Q", 32'(q_b), 32'h0);
    step_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
